// File: rtl/parking_manager.sv
// Occupancy manager for a shared university/general lot with an hour-dependent capacity split.
// Optional build macro PARKING_EVICT_EN: clamp over-capacity counts to capacity on the next edge.
module parking_manager #(
    parameter int TOTAL_SPACES = 700,
    parameter int HOUR_CYCLES  = 700,
    parameter int START_HOUR   = 8
) (
    input  logic       CLK,
    input  logic       Start,
    input  logic       car_entered,
    input  logic       is_uni_car_entered,
    input  logic       car_exited,
    input  logic       is_uni_car_exited,
    output logic [9:0] uni_parked_car,
    output logic [9:0] parked_car,
    output logic [9:0] uni_vacated_space,
    output logic [9:0] vacated_space,
    output logic       uni_is_vacated_space,
    output logic       is_vacated_space,
    output logic       overflow_uni,
    output logic       overflow,
    output logic       rejected_uni,
    output logic       rejected,
    output logic [4:0] hour
);

    localparam int CW = (HOUR_CYCLES > 1) ? $clog2(HOUR_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_CYCLE = CW'(HOUR_CYCLES - 1);
    localparam logic [4:0]    RESET_HOUR = 5'(START_HOUR);

    typedef struct packed {
        logic       rej;
        logic [9:0] cnt;
    } upd_t;

    function automatic logic [9:0] uni_cap_f(input logic [4:0] h);
        logic [9:0] c;
        if (h >= 5'd8 && h <= 5'd12) c = 10'd500;
        else if (h == 5'd13)         c = 10'd450;
        else if (h == 5'd14)         c = 10'd400;
        else if (h == 5'd15)         c = 10'd350;
        else                         c = 10'd200;
        return c;
    endfunction

    function automatic logic [9:0] gen_cap_f(input logic [4:0] h);
        return 10'(TOTAL_SPACES) - uni_cap_f(h);
    endfunction

    function automatic logic [9:0] free_f(input logic [9:0] cap, input logic [9:0] cnt);
        return (cnt > cap) ? 10'd0 : cap - cnt;
    endfunction

    // Exit is applied first so a same-class exit can make room for the entry.
    function automatic upd_t class_update(input logic [9:0] cnt, input logic [9:0] cap,
                                          input logic ent, input logic ext);
        upd_t       r;
        logic [9:0] after;
        after = (ext && cnt != 10'd0) ? cnt - 10'd1 : cnt;
        r.cnt = after;
        r.rej = 1'b0;
        if (ent) begin
            if (after < cap) r.cnt = after + 10'd1;
            else             r.rej = 1'b1;
        end
`ifdef PARKING_EVICT_EN
        if (cnt > cap) r.cnt = cap;
`endif
        return r;
    endfunction

    logic [CW-1:0] cyc_q, cyc_d;
    logic [4:0]    hour_q, hour_d;
    logic [9:0]    uni_cnt_q, uni_cnt_d, gen_cnt_q, gen_cnt_d;
    logic [9:0]    uni_free_q, uni_free_d, gen_free_q, gen_free_d;
    logic          uni_ovf_q, uni_ovf_d, gen_ovf_q, gen_ovf_d;
    logic          uni_rej_q, uni_rej_d, gen_rej_q, gen_rej_d;
    logic [9:0]    uni_cap_now, gen_cap_now, uni_cap_next, gen_cap_next;
    upd_t          uni_upd, gen_upd;

    always_comb begin
        cyc_d  = cyc_q + CW'(1);
        hour_d = hour_q;
        if (cyc_q == LAST_CYCLE) begin
            cyc_d  = '0;
            hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
        end

        uni_cap_now = uni_cap_f(hour_q);
        gen_cap_now = gen_cap_f(hour_q);

        uni_upd = class_update(uni_cnt_q, uni_cap_now,
                               car_entered & is_uni_car_entered,
                               car_exited & is_uni_car_exited);
        gen_upd = class_update(gen_cnt_q, gen_cap_now,
                               car_entered & ~is_uni_car_entered,
                               car_exited & ~is_uni_car_exited);

        uni_cnt_d = uni_upd.cnt;
        gen_cnt_d = gen_upd.cnt;
        uni_rej_d = uni_upd.rej;
        gen_rej_d = gen_upd.rej;

        // Status is derived from the post-update counts and the post-update hour.
        uni_cap_next = uni_cap_f(hour_d);
        gen_cap_next = gen_cap_f(hour_d);
        uni_free_d   = free_f(uni_cap_next, uni_cnt_d);
        gen_free_d   = free_f(gen_cap_next, gen_cnt_d);
        uni_ovf_d    = uni_cnt_d > uni_cap_next;
        gen_ovf_d    = gen_cnt_d > gen_cap_next;
    end

    always_ff @(posedge CLK) begin
        if (Start) begin
            cyc_q      <= '0;
            hour_q     <= RESET_HOUR;
            uni_cnt_q  <= '0;
            gen_cnt_q  <= '0;
            uni_free_q <= uni_cap_f(RESET_HOUR);
            gen_free_q <= gen_cap_f(RESET_HOUR);
            uni_ovf_q  <= 1'b0;
            gen_ovf_q  <= 1'b0;
            uni_rej_q  <= 1'b0;
            gen_rej_q  <= 1'b0;
        end else begin
            cyc_q      <= cyc_d;
            hour_q     <= hour_d;
            uni_cnt_q  <= uni_cnt_d;
            gen_cnt_q  <= gen_cnt_d;
            uni_free_q <= uni_free_d;
            gen_free_q <= gen_free_d;
            uni_ovf_q  <= uni_ovf_d;
            gen_ovf_q  <= gen_ovf_d;
            uni_rej_q  <= uni_rej_d;
            gen_rej_q  <= gen_rej_d;
        end
    end

    assign uni_parked_car       = uni_cnt_q;
    assign parked_car           = gen_cnt_q;
    assign uni_vacated_space    = uni_free_q;
    assign vacated_space        = gen_free_q;
    assign uni_is_vacated_space = uni_free_q != 10'd0;
    assign is_vacated_space     = gen_free_q != 10'd0;
    assign overflow_uni         = uni_ovf_q;
    assign overflow             = gen_ovf_q;
    assign rejected_uni         = uni_rej_q;
    assign rejected             = gen_rej_q;
    assign hour                 = hour_q;

endmodule

// File: tb/tb_parking_manager.sv
// Bench for parking_manager: directed scenarios plus random traffic checked against a
// behavioural model that derives the hour from elapsed cycles since reset.
module tb_parking_manager;

  localparam int TOTAL = 700;
  localparam int HCYC  = 700;
  localparam int SHOUR = 8;

  logic       CLK;
  logic       Start;
  logic       car_entered, is_uni_car_entered, car_exited, is_uni_car_exited;
  logic [9:0] uni_parked_car, parked_car, uni_vacated_space, vacated_space;
  logic       uni_is_vacated_space, is_vacated_space, overflow_uni, overflow;
  logic       rejected_uni, rejected;
  logic [4:0] hour;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int m_uni, m_gen, m_cycles;
  bit m_rej_uni, m_rej_gen;

  parking_manager #(.TOTAL_SPACES(TOTAL), .HOUR_CYCLES(HCYC), .START_HOUR(SHOUR)) dut (
    .CLK(CLK), .Start(Start),
    .car_entered(car_entered), .is_uni_car_entered(is_uni_car_entered),
    .car_exited(car_exited), .is_uni_car_exited(is_uni_car_exited),
    .uni_parked_car(uni_parked_car), .parked_car(parked_car),
    .uni_vacated_space(uni_vacated_space), .vacated_space(vacated_space),
    .uni_is_vacated_space(uni_is_vacated_space), .is_vacated_space(is_vacated_space),
    .overflow_uni(overflow_uni), .overflow(overflow),
    .rejected_uni(rejected_uni), .rejected(rejected), .hour(hour)
  );

  // clock / reset block
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int hour_of(input int cycles);
    return (SHOUR + cycles / HCYC) % 24;
  endfunction

  function automatic int uni_cap(input int h);
    if (h >= 8 && h <= 12) return 500;
    if (h == 13) return 450;
    if (h == 14) return 400;
    if (h == 15) return 350;
    return 200;
  endfunction

  function automatic int max0(input int v);
    return (v < 0) ? 0 : v;
  endfunction

  task automatic model_step(input bit st, input bit ent, input bit eu, input bit ex, input bit xu);
    int ucap, gcap, old_u, old_g;
    if (st) begin
      m_uni = 0; m_gen = 0; m_cycles = 0; m_rej_uni = 0; m_rej_gen = 0;
      return;
    end
    ucap = uni_cap(hour_of(m_cycles));
    gcap = TOTAL - ucap;
    old_u = m_uni;
    old_g = m_gen;
    m_rej_uni = 0;
    m_rej_gen = 0;
    if (ex && xu && m_uni > 0) m_uni--;
    if (ex && !xu && m_gen > 0) m_gen--;
    if (ent && eu) begin
      if (m_uni < ucap) m_uni++; else m_rej_uni = 1;
    end
    if (ent && !eu) begin
      if (m_gen < gcap) m_gen++; else m_rej_gen = 1;
    end
`ifdef PARKING_EVICT_EN
    if (old_u > ucap) m_uni = ucap;
    if (old_g > gcap) m_gen = gcap;
`endif
    m_cycles++;
  endtask

  task automatic compare_all();
    int h, ucap, gcap;
    h = hour_of(m_cycles);
    ucap = uni_cap(h);
    gcap = TOTAL - ucap;
    check("uni_parked", int'(uni_parked_car), m_uni);
    check("gen_parked", int'(parked_car), m_gen);
    check("uni_free", int'(uni_vacated_space), max0(ucap - m_uni));
    check("gen_free", int'(vacated_space), max0(gcap - m_gen));
    check("uni_has_free", int'(uni_is_vacated_space), int'(ucap > m_uni));
    check("gen_has_free", int'(is_vacated_space), int'(gcap > m_gen));
    check("uni_ovf", int'(overflow_uni), int'(m_uni > ucap));
    check("gen_ovf", int'(overflow), int'(m_gen > gcap));
    check("uni_rej", int'(rejected_uni), int'(m_rej_uni));
    check("gen_rej", int'(rejected), int'(m_rej_gen));
    check("hour", int'(hour), h);
  endtask

  // driver task: one clock of stimulus, then model update and full comparison
  task automatic cycle(input bit st, input bit ent, input bit eu, input bit ex, input bit xu);
    Start = st;
    car_entered = ent; is_uni_car_entered = eu;
    car_exited = ex;   is_uni_car_exited = xu;
    @(posedge CLK);
    #1;
    model_step(st, ent, eu, ex, xu);
    compare_all();
  endtask

  initial begin
    int rej_seen;
    bit saw_wrap;
    int prev_hour;

    m_uni = 0; m_gen = 0; m_cycles = 0; m_rej_uni = 0; m_rej_gen = 0;

    // reset state
    cycle(1, 0, 0, 0, 0);
    check("rst_uni_free", int'(uni_vacated_space), 500);
    check("rst_gen_free", int'(vacated_space), 200);
    check("rst_hour", int'(hour), 8);

    // 100 university entries
    for (int i = 0; i < 100; i++) cycle(0, 1, 1, 0, 0);
    check("uni100_parked", int'(uni_parked_car), 100);
    check("uni100_free", int'(uni_vacated_space), 400);

    // 250 general entries from empty: 50 refused
    cycle(1, 0, 0, 0, 0);
    rej_seen = 0;
    for (int i = 0; i < 250; i++) begin
      cycle(0, 1, 0, 0, 0);
      if (rejected) rej_seen++;
    end
    check("gen_fill_parked", int'(parked_car), 200);
    check("gen_fill_free", int'(vacated_space), 0);
    check("gen_fill_has_free", int'(is_vacated_space), 0);
    check("gen_rej_count", rej_seen, 50);

    // fill university, advance to hour 16
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 500; i++) cycle(0, 1, 1, 0, 0);
    while (m_cycles < 8 * HCYC) cycle(0, 0, 0, 0, 0);
    check("h16_hour", int'(hour), 16);
    check("h16_uni_ovf", int'(overflow_uni), 1);
    check("h16_uni_free", int'(uni_vacated_space), 0);
    cycle(0, 0, 0, 0, 0);
`ifdef PARKING_EVICT_EN
    check("h16_evict_parked", int'(uni_parked_car), 200);
    check("h16_evict_ovf", int'(overflow_uni), 0);
`else
    check("h16_keep_parked", int'(uni_parked_car), 500);
    check("h16_keep_ovf", int'(overflow_uni), 1);
`endif

    // uni entry at uni full plus same-cycle general exit
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 500; i++) cycle(0, 1, 1, 0, 0);
    for (int i = 0; i < 10; i++) cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 1, 1, 0);
    check("mix_uni_rej", int'(rejected_uni), 1);
    check("mix_gen_parked", int'(parked_car), 9);
    check("mix_uni_parked", int'(uni_parked_car), 500);
    cycle(0, 0, 0, 0, 0);
    check("mix_uni_rej_clear", int'(rejected_uni), 0);

    // same-class entry and exit at full: accepted, net zero
    cycle(0, 1, 1, 1, 1);
    check("same_uni_rej", int'(rejected_uni), 0);
    check("same_uni_parked", int'(uni_parked_car), 500);

    // exits from empty, then a full day to see the hour wrap
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 1);
    cycle(0, 0, 0, 1, 0);
    check("empty_exit_uni", int'(uni_parked_car), 0);
    check("empty_exit_gen", int'(parked_car), 0);
    check("empty_exit_rej", int'(rejected) + int'(rejected_uni), 0);
    saw_wrap = 0;
    prev_hour = int'(hour);
    while (m_cycles < 24 * HCYC) begin
      cycle(0, 0, 0, 0, 0);
      if (prev_hour == 23 && int'(hour) == 0) saw_wrap = 1;
      prev_hour = int'(hour);
    end
    check("day_hour", int'(hour), 8);
    check("day_wrap_seen", int'(saw_wrap), 1);

    // Start mid-stream overrides an entry
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 30; i++) cycle(0, 1, i[0], 0, 0);
    cycle(1, 1, 1, 0, 0);
    check("midrst_uni", int'(uni_parked_car), 0);
    check("midrst_gen", int'(parked_car), 0);
    check("midrst_hour", int'(hour), 8);
    check("midrst_uni_free", int'(uni_vacated_space), 500);
    check("midrst_gen_free", int'(vacated_space), 200);

    // random traffic across many hours
    for (int i = 0; i < 9000; i++) begin
      cycle($urandom_range(0, 3999) == 0,
            $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
            $urandom_range(0, 9) < 4, $urandom_range(0, 1) == 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
